// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and defaults for the cache line-fill arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_arb_pkg;

  localparam int DEF_ADDR_W     = 26;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MAX_OUT    = 2;
  localparam int DEF_CNT_W      = 32;

  // Width of the in-flight fill counter (MAX_OUT tops out at 7).
  localparam int OUT_W = 3;

  localparam logic SRC_IC = 1'b0;
  localparam logic SRC_DC = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BLOCKED
  } arb_state_t;

  // Round-robin pick: a lone non-empty queue wins, a tie goes to the
  // source that did not win last time.
  function automatic logic pick_dc(input logic ic_ne, input logic dc_ne,
                                   input logic last_grant);
    return dc_ne && (!ic_ne || (last_grant == SRC_IC));
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Bundle of the cache request, next-level request/response and stats signals.
// Latency: n/a (wiring only).
// Backpressure: ready/valid on both cache ports and on the next-level request.
interface cache_fill_arbiter_if
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;

  logic              dc_req_valid;
  logic              dc_req_ready;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_req_we;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_src;
  logic              mem_req_we;

  logic              mem_rsp_valid;
  logic              mem_rsp_src;

  logic              ic_fill_done;
  logic              dc_fill_done;
  logic [OUT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  ic_grants;
  logic [CNT_W-1:0]  dc_grants;
  logic [CNT_W-1:0]  conflicts;
  logic              rsp_err;

  // Caches plus next level: drive requests, ready and responses.
  modport master (
    output ic_req_valid, ic_req_addr,
    output dc_req_valid, dc_req_addr, dc_req_we,
    output mem_req_ready, mem_rsp_valid, mem_rsp_src,
    input  ic_req_ready, dc_req_ready,
    input  mem_req_valid, mem_req_addr, mem_req_src, mem_req_we,
    input  ic_fill_done, dc_fill_done, outstanding,
    input  ic_grants, dc_grants, conflicts, rsp_err
  );

  // The arbiter itself.
  modport slave (
    input  ic_req_valid, ic_req_addr,
    input  dc_req_valid, dc_req_addr, dc_req_we,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_src,
    output ic_req_ready, dc_req_ready,
    output mem_req_valid, mem_req_addr, mem_req_src, mem_req_we,
    output ic_fill_done, dc_fill_done, outstanding,
    output ic_grants, dc_grants, conflicts, rsp_err
  );

endinterface

// File: rtl/cache_fill_arbiter_fifo.sv
// Per-source request queue: circular buffer with wrap-around pointers and a count.
// Latency: a push is visible at the head (empty deasserts) one cycle later.
// Backpressure: full comes straight from the count register; pushes when full and pops when empty are ignored.
module fill_req_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear drops every entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge clk) begin
    if (push_en && !clear) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Round-robin arbiter sharing the next-level line-fill port between IC and DC queues.
// Latency: request accepted at edge N on an idle system is presented on mem_req_* after edge N+1.
// Backpressure: mem_req_* held stable until mem_req_ready; cache ready drops when its queue fills, during clear, or while in-flight fills reach MAX_OUT.
module cache_fill_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_OUT    = DEF_MAX_OUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  clear,
  cache_fill_arbiter_if.slave  bus
);

  localparam int ENT_W = ADDR_W + 1;
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  arb_state_t        state;
  arb_state_t        state_nxt;

  logic              ready_en;
  logic              last_grant;

  logic              ic_push, dc_push;
  logic              ic_pop, dc_pop;
  logic              ic_full, dc_full;
  logic              ic_empty, dc_empty;
  logic [ENT_W-1:0]  ic_head, dc_head, sel_head;
  logic              ic_ne, dc_ne, any_ne;
  logic              win_dc;
  logic              load;

  logic              mem_hs;
  logic              rsp_ok;
  logic              rsp_bad;
  logic [OUT_W-1:0]  out_cnt;
  logic [OUT_W-1:0]  out_after_rsp;
  logic              room_idle;
  logic              room_issue;

  logic [ADDR_W-1:0] req_addr_q;
  logic              req_src_q;
  logic              req_we_q;
  logic              ic_done_q, dc_done_q;
  logic [CNT_W-1:0]  ic_grants_q, dc_grants_q, conflicts_q;
  logic              rsp_err_q;

  // ---------------- enqueue side ----------------
  // ready_en keeps both readies low while reset is asserted and is a flop,
  // so ready never depends on the incoming valid.
  assign bus.ic_req_ready = ready_en && !ic_full && !clear;
  assign bus.dc_req_ready = ready_en && !dc_full && !clear;
  assign ic_push = bus.ic_req_valid && bus.ic_req_ready;
  assign dc_push = bus.dc_req_valid && bus.dc_req_ready;

  fill_req_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_ic_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (ic_push),
    .push_dat ({1'b0, bus.ic_req_addr}),
    .pop      (ic_pop),
    .pop_dat  (ic_head),
    .full     (ic_full),
    .empty    (ic_empty)
  );

  fill_req_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_dc_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (dc_push),
    .push_dat ({bus.dc_req_we, bus.dc_req_addr}),
    .pop      (dc_pop),
    .pop_dat  (dc_head),
    .full     (dc_full),
    .empty    (dc_empty)
  );

  // ---------------- arbitration ----------------
  // Queues being flushed by clear are treated as empty so nothing is popped.
  assign ic_ne    = !ic_empty && !clear;
  assign dc_ne    = !dc_empty && !clear;
  assign any_ne   = ic_ne || dc_ne;
  assign win_dc   = pick_dc(ic_ne, dc_ne, last_grant);
  assign ic_pop   = load && !win_dc;
  assign dc_pop   = load && win_dc;
  assign sel_head = win_dc ? dc_head : ic_head;

  // ---------------- in-flight accounting ----------------
  assign mem_hs        = bus.mem_req_valid && bus.mem_req_ready;
  assign rsp_ok        = bus.mem_rsp_valid && (out_cnt != '0);
  assign rsp_bad       = bus.mem_rsp_valid && (out_cnt == '0);
  assign out_after_rsp = out_cnt - {{(OUT_W-1){1'b0}}, rsp_ok};
  // Waiting states may reuse a slot freed by a response in this very cycle.
  assign room_idle     = (out_after_rsp < MAX_OUT_C);
  // In ISSUE the acceptance being made takes a slot: out_cnt + 1 < MAX_OUT.
  assign room_issue    = (out_cnt < (MAX_OUT_C - OUT_W'(1)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and pop decision; load moves the winner into the output register.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE, BLOCKED: begin
        if (any_ne) begin
          if (room_idle) begin
            load      = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = BLOCKED;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready) begin
          if (any_ne && room_issue) begin
            load      = 1'b1;
            state_nxt = ISSUE;
          end else if (any_ne) begin
            state_nxt = BLOCKED;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready enable comes up on the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Output request register; only reloaded on a pop, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q <= '0;
      req_src_q  <= SRC_IC;
      req_we_q   <= 1'b0;
    end else if (load) begin
      req_addr_q <= sel_head[ADDR_W-1:0];
      req_src_q  <= win_dc;
      req_we_q   <= sel_head[ADDR_W];
    end
  end

  // Round-robin pointer: remembers the source of the most recent pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant <= SRC_DC;
    else if (clear) last_grant <= SRC_DC;
    else if (load)  last_grant <= win_dc;
  end

  // In-flight fill count; clear leaves it alone so late responses still match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else begin
      case ({mem_hs, rsp_ok})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Completion pulses, one cycle after a response that matched an in-flight fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
    end else begin
      ic_done_q <= rsp_ok && (bus.mem_rsp_src == SRC_IC);
      dc_done_q <= rsp_ok && (bus.mem_rsp_src == SRC_DC);
    end
  end

  // Statistics; a handshake landing in the clear cycle still counts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_grants_q <= '0;
      dc_grants_q <= '0;
      conflicts_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ic_grants_q <= (clear ? '0 : ic_grants_q) + CNT_W'(mem_hs && (req_src_q == SRC_IC));
      dc_grants_q <= (clear ? '0 : dc_grants_q) + CNT_W'(mem_hs && (req_src_q == SRC_DC));
      conflicts_q <= (clear ? '0 : conflicts_q) + CNT_W'(load && ic_ne && dc_ne);
      rsp_err_q   <= (rsp_err_q && !clear) || rsp_bad;
    end
  end

  assign bus.mem_req_valid = (state == ISSUE);
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_src   = req_src_q;
  assign bus.mem_req_we    = req_we_q;
  assign bus.ic_fill_done  = ic_done_q;
  assign bus.dc_fill_done  = dc_done_q;
  assign bus.outstanding   = out_cnt;
  assign bus.ic_grants     = ic_grants_q;
  assign bus.dc_grants     = dc_grants_q;
  assign bus.conflicts     = conflicts_q;
  assign bus.rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with hand-computed expectations.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: mem_req_ready is stepped by the stimulus to hold and release requests.
module tb_cache_fill_arbiter;

  logic clk;
  logic rst_n;
  logic clear;

  int n_tests = 0;
  int n_fail  = 0;

  cache_fill_arbiter_if #(.ADDR_W(26), .CNT_W(32)) arb_if ();

  cache_fill_arbiter #(
    .ADDR_W     (26),
    .FIFO_DEPTH (4),
    .MAX_OUT    (2),
    .CNT_W      (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (arb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                = 1'b0;
    clear                = 1'b0;
    arb_if.ic_req_valid  = 1'b0;
    arb_if.ic_req_addr   = '0;
    arb_if.dc_req_valid  = 1'b0;
    arb_if.dc_req_addr   = '0;
    arb_if.dc_req_we     = 1'b0;
    arb_if.mem_req_ready = 1'b0;
    arb_if.mem_rsp_valid = 1'b0;
    arb_if.mem_rsp_src   = 1'b0;

    // ---- reset state ----
    #2;
    check("rst_valid", arb_if.mem_req_valid, 0);
    check("rst_ic_ready", arb_if.ic_req_ready, 0);
    check("rst_outstanding", arb_if.outstanding, 0);
    check("rst_ic_grants", arb_if.ic_grants, 0);
    check("rst_rsp_err", arb_if.rsp_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("idle_ic_ready", arb_if.ic_req_ready, 1);
    check("idle_dc_ready", arb_if.dc_req_ready, 1);

    // ---- IC only, back-to-back issue then BLOCKED at MAX_OUT ----
    arb_if.mem_req_ready = 1'b1;
    arb_if.ic_req_valid  = 1'b1;
    arb_if.ic_req_addr   = 26'h40;
    tick();
    arb_if.ic_req_addr = 26'h41;
    tick();
    check("t1_valid_a", arb_if.mem_req_valid, 1);
    check("t1_addr_a", arb_if.mem_req_addr, 32'h40);
    check("t1_src_a", arb_if.mem_req_src, 0);
    arb_if.ic_req_addr = 26'h42;
    tick();
    check("t1_valid_b", arb_if.mem_req_valid, 1);
    check("t1_addr_b", arb_if.mem_req_addr, 32'h41);
    check("t1_out_1", arb_if.outstanding, 1);
    check("t1_grants_1", arb_if.ic_grants, 1);
    arb_if.ic_req_addr = 26'h43;
    tick();
    check("t1_blocked_valid", arb_if.mem_req_valid, 0);
    check("t1_grants_2", arb_if.ic_grants, 2);
    check("t1_out_2", arb_if.outstanding, 2);
    check("t1_ready_q2", arb_if.ic_req_ready, 1);
    arb_if.ic_req_addr = 26'h44;
    tick();
    check("t1_ready_q3", arb_if.ic_req_ready, 1);
    arb_if.ic_req_addr = 26'h45;
    tick();
    arb_if.ic_req_valid = 1'b0;
    check("t1_ready_full", arb_if.ic_req_ready, 0);
    check("t1_still_blocked", arb_if.mem_req_valid, 0);

    // ---- outstanding limit: a response frees a slot ----
    arb_if.mem_rsp_valid = 1'b1;
    arb_if.mem_rsp_src   = 1'b1;
    tick();
    arb_if.mem_rsp_valid = 1'b0;
    check("t4_issue_valid", arb_if.mem_req_valid, 1);
    check("t4_issue_addr", arb_if.mem_req_addr, 32'h42);
    check("t4_dc_done", arb_if.dc_fill_done, 1);
    check("t4_ic_done", arb_if.ic_fill_done, 0);
    check("t4_out", arb_if.outstanding, 1);
    tick();
    check("t4_reblock_valid", arb_if.mem_req_valid, 0);
    check("t4_dc_done_end", arb_if.dc_fill_done, 0);
    check("t4_out_2", arb_if.outstanding, 2);
    check("t4_grants", arb_if.ic_grants, 3);

    // ---- same-cycle handshake and response at outstanding = 1 ----
    arb_if.mem_rsp_valid = 1'b1;
    arb_if.mem_rsp_src   = 1'b0;
    tick();
    check("t5_addr", arb_if.mem_req_addr, 32'h43);
    check("t5_ic_done", arb_if.ic_fill_done, 1);
    check("t5_out_pre", arb_if.outstanding, 1);
    tick();
    arb_if.mem_rsp_valid = 1'b0;
    check("t5_same_out", arb_if.outstanding, 1);
    check("t5_grants", arb_if.ic_grants, 4);
    check("t5_blocked", arb_if.mem_req_valid, 0);
    tick();
    check("t5_next_valid", arb_if.mem_req_valid, 1);
    check("t5_next_addr", arb_if.mem_req_addr, 32'h44);

    // ---- backpressure: hold for 5 cycles ----
    arb_if.mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", arb_if.mem_req_valid, 1);
      check("bp_addr", arb_if.mem_req_addr, 32'h44);
      check("bp_src_we", {arb_if.mem_req_src, arb_if.mem_req_we}, 0);
    end
    check("bp_grants_held", arb_if.ic_grants, 4);
    arb_if.mem_req_ready = 1'b1;
    tick();
    check("bp_grants_rel", arb_if.ic_grants, 5);
    check("bp_out", arb_if.outstanding, 2);
    check("bp_blocked", arb_if.mem_req_valid, 0);

    // ---- drain, then a spurious response ----
    arb_if.mem_rsp_valid = 1'b1;
    arb_if.mem_rsp_src   = 1'b0;
    tick();
    arb_if.mem_rsp_valid = 1'b0;
    check("dr_addr", arb_if.mem_req_addr, 32'h45);
    tick();
    check("dr_idle", arb_if.mem_req_valid, 0);
    check("dr_out_2", arb_if.outstanding, 2);
    check("dr_grants", arb_if.ic_grants, 6);
    arb_if.mem_rsp_valid = 1'b1;
    tick();
    tick();
    arb_if.mem_rsp_valid = 1'b0;
    check("dr_out_0", arb_if.outstanding, 0);
    check("dr_no_err", arb_if.rsp_err, 0);
    arb_if.mem_rsp_valid = 1'b1;
    tick();
    arb_if.mem_rsp_valid = 1'b0;
    check("sp_rsp_err", arb_if.rsp_err, 1);
    check("sp_no_done", arb_if.ic_fill_done, 0);
    check("sp_out", arb_if.outstanding, 0);

    // ---- clear with nothing in flight; push during clear refused ----
    clear               = 1'b1;
    arb_if.ic_req_valid = 1'b1;
    arb_if.ic_req_addr  = 26'h99;
    #0;
    check("clr_ic_ready", arb_if.ic_req_ready, 0);
    check("clr_dc_ready", arb_if.dc_req_ready, 0);
    tick();
    clear               = 1'b0;
    arb_if.ic_req_valid = 1'b0;
    check("clr_ic_grants", arb_if.ic_grants, 0);
    check("clr_rsp_err", arb_if.rsp_err, 0);
    tick();
    check("clr_push_refused", arb_if.mem_req_valid, 0);

    // ---- both queues loaded, round-robin with conflicts ----
    arb_if.ic_req_valid = 1'b1;
    arb_if.ic_req_addr  = 26'h100;
    arb_if.dc_req_valid = 1'b1;
    arb_if.dc_req_addr  = 26'h200;
    arb_if.dc_req_we    = 1'b1;
    tick();
    arb_if.ic_req_addr = 26'h101;
    arb_if.dc_req_addr = 26'h201;
    arb_if.dc_req_we   = 1'b0;
    tick();
    arb_if.ic_req_valid = 1'b0;
    arb_if.dc_req_valid = 1'b0;
    check("t2_a0_addr", arb_if.mem_req_addr, 32'h100);
    check("t2_a0_src_we", {arb_if.mem_req_src, arb_if.mem_req_we}, 0);
    tick();
    check("t2_b0_addr", arb_if.mem_req_addr, 32'h200);
    check("t2_b0_src_we", {arb_if.mem_req_src, arb_if.mem_req_we}, 3);
    arb_if.mem_rsp_valid = 1'b1;
    arb_if.mem_rsp_src   = 1'b0;
    tick();
    arb_if.mem_rsp_valid = 1'b0;
    check("t2_gap_valid", arb_if.mem_req_valid, 0);
    check("t2_gap_out", arb_if.outstanding, 1);
    tick();
    check("t2_a1_addr", arb_if.mem_req_addr, 32'h101);
    check("t2_a1_src_we", {arb_if.mem_req_src, arb_if.mem_req_we}, 0);
    arb_if.mem_rsp_valid = 1'b1;
    arb_if.mem_rsp_src   = 1'b1;
    tick();
    arb_if.mem_rsp_valid = 1'b0;
    check("t2_dc_done", arb_if.dc_fill_done, 1);
    tick();
    check("t2_b1_addr", arb_if.mem_req_addr, 32'h201);
    check("t2_b1_src_we", {arb_if.mem_req_src, arb_if.mem_req_we}, 2);
    arb_if.mem_rsp_valid = 1'b1;
    arb_if.mem_rsp_src   = 1'b0;
    tick();
    arb_if.mem_rsp_valid = 1'b0;
    check("t2_conflicts", arb_if.conflicts, 3);
    check("t2_ic_grants", arb_if.ic_grants, 2);
    check("t2_dc_grants", arb_if.dc_grants, 2);
    check("t2_idle", arb_if.mem_req_valid, 0);
    arb_if.mem_rsp_valid = 1'b1;
    arb_if.mem_rsp_src   = 1'b1;
    tick();
    arb_if.mem_rsp_valid = 1'b0;
    check("t2_out_0", arb_if.outstanding, 0);

    // ---- clear with 3 queued and one held in ISSUE ----
    arb_if.mem_req_ready = 1'b0;
    arb_if.ic_req_valid  = 1'b1;
    arb_if.ic_req_addr   = 26'h300;
    tick();
    arb_if.ic_req_addr = 26'h301;
    tick();
    arb_if.ic_req_addr = 26'h302;
    tick();
    arb_if.ic_req_addr = 26'h303;
    tick();
    arb_if.ic_req_valid = 1'b0;
    check("t6_held_addr", arb_if.mem_req_addr, 32'h300);
    check("t6_q3_ready", arb_if.ic_req_ready, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t6_held_valid", arb_if.mem_req_valid, 1);
    check("t6_held_addr2", arb_if.mem_req_addr, 32'h300);
    check("t6_clr_ic_grants", arb_if.ic_grants, 0);
    check("t6_clr_dc_grants", arb_if.dc_grants, 0);
    check("t6_clr_conflicts", arb_if.conflicts, 0);
    arb_if.mem_req_ready = 1'b1;
    tick();
    check("t6_grant_after", arb_if.ic_grants, 1);
    check("t6_out", arb_if.outstanding, 1);
    tick();
    tick();
    check("t6_queues_empty", arb_if.mem_req_valid, 0);

    // ---- asynchronous reset in the middle of ISSUE ----
    arb_if.mem_req_ready = 1'b0;
    arb_if.ic_req_valid  = 1'b1;
    arb_if.ic_req_addr   = 26'h3ff;
    tick();
    arb_if.ic_req_valid = 1'b0;
    tick();
    check("t7_pre_valid", arb_if.mem_req_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_valid", arb_if.mem_req_valid, 0);
    check("t7_addr", arb_if.mem_req_addr, 0);
    check("t7_out", arb_if.outstanding, 0);
    check("t7_ic_grants", arb_if.ic_grants, 0);
    check("t7_ic_ready", arb_if.ic_req_ready, 0);
    #2 rst_n = 1'b1;
    tick();
    check("t7_post_valid", arb_if.mem_req_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
Shares the single next-level (L2/memory) line-fill port between the instruction cache and the data cache. Each cache pushes miss and eviction requests into a small per-source queue. The arbiter issues them to the next level round-robin under a valid/ready handshake, tracks outstanding fills and routes responses back to the source cache. It keeps grant and conflict statistics for the statistics module.

Parameters:
ADDR_W, 26, line address width (add_in[31:6]).
FIFO_DEPTH, 4, entries per source queue; must be a power of 2 and at least 2.
MAX_OUT, 2, maximum fills in flight at the next level; range 1..7.
CNT_W, 32, width of the statistics counters.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous and active-low.
clear  in  1  synchronous soft clear, driven when the trace command is RESET (n=8).
ic_req_valid  in  1  instruction cache fill request.
ic_req_ready  out  1  IC queue can accept a request.
ic_req_addr  in  ADDR_W  IC line address.
dc_req_valid  in  1  data cache request.
dc_req_ready  out  1  DC queue can accept a request.
dc_req_addr  in  ADDR_W  DC line address.
dc_req_we  in  1  1 = writeback eviction, 0 = fill.
mem_req_valid  out  1  request to the next level.
mem_req_ready  in  1  next level accepts the request.
mem_req_addr  out  ADDR_W  issued line address.
mem_req_src  out  1  0 = IC, 1 = DC.
mem_req_we  out  1  write flag; always 0 when src = IC.
mem_rsp_valid  in  1  fill or writeback complete (one cycle pulse).
mem_rsp_src  in  1  source of the completing request.
ic_fill_done  out  1  one-cycle pulse: IC response returned.
dc_fill_done  out  1  one-cycle pulse: DC response returned.
outstanding  out  3  fills currently in flight.
ic_grants  out  CNT_W  IC requests issued.
dc_grants  out  CNT_W  DC requests issued.
conflicts  out  CNT_W  arbitration decisions made with both queues non-empty.
rsp_err  out  1  sticky flag: response received with outstanding = 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0; both queues empty; FSM in IDLE; outstanding 0; counters 0; rsp_err 0.
  - last_grant = DC, so IC wins the first tie.
- Enqueue:
  - x_req_ready = !queue_full && !clear.
  - A request is pushed when x_req_valid && x_req_ready.
  - No combinational path from x_req_valid to x_req_ready.
- Output register: mem_req_valid/addr/src/we are registered. They must stay stable while mem_req_valid && !mem_req_ready.
- FSM:
  - IDLE: mem_req_valid = 0. When any queue is non-empty and outstanding < MAX_OUT, pop the winner into the output register and go to ISSUE. If a queue is non-empty but outstanding = MAX_OUT, go to BLOCKED.
  - ISSUE: mem_req_valid = 1. On mem_req_ready:
    - If another request is eligible, pop it into the output register in the same cycle and stay in ISSUE (back-to-back, no bubble). Eligibility counts the acceptance just made: outstanding + 1 < MAX_OUT.
    - Otherwise go to BLOCKED if work is queued, else IDLE.
  - BLOCKED: mem_req_valid = 0. Go to ISSUE (popping the winner) as soon as outstanding < MAX_OUT, including the cycle in which a response decrements it.
- Arbitration:
  - If only one queue is non-empty, it wins.
  - If both are non-empty, the source opposite last_grant wins and conflicts increments.
  - last_grant updates on pop.
  - Grant counters increment on the mem handshake, not on pop, and wrap modulo 2^CNT_W.
- Latency: a request accepted at edge N, with an empty system, gives mem_req_valid high after edge N+1.
- Outstanding count:
  - Increment on the mem handshake; decrement on mem_rsp_valid.
  - Both in the same cycle: unchanged.
  - mem_rsp_valid while outstanding = 0: count stays 0, rsp_err is set, no done pulse.
- Responses: x_fill_done pulses one cycle after mem_rsp_valid (registered), selected by mem_rsp_src.
- Clear (synchronous):
  - Empties both queues and zeroes the three counters and rsp_err; last_grant = DC.
  - Does not drop a request currently held in ISSUE; the handshake completes and is counted.
  - Does not change outstanding; in-flight responses still pulse done.
  - A push presented in the clear cycle is refused (ready = 0).
- Queues: wrap-around pointers plus a count. Push and pop on the same cycle of a full queue is not possible, because ready is computed from the registered full flag.

Decomposition:
- Package cache_arb_pkg:
  - SRC_IC = 1'b0, SRC_DC = 1'b1.
  - FSM state typedef {IDLE, ISSUE, BLOCKED}.
  - Default widths.
- Sub-module fill_req_fifo (data = ADDR_W+1 bits, depth = FIFO_DEPTH), instantiated once per source.

Test Plan:
- IC only: push addresses 0x0000040, 0x0000041 with mem_req_ready = 1 and no responses (MAX_OUT = 2) -> two issues in consecutive cycles, then BLOCKED; ic_grants = 2; IC ready stays 1 until the queue is full.
- Both queues loaded: IC {A0, A1}, DC {B0(we = 1), B1}, responses returned immediately -> issue order A0, B0, A1, B1; conflicts = 3; mem_req_we = 1 only on B0.
- Backpressure: hold mem_req_ready = 0 for 5 cycles -> addr/src/we unchanged throughout; one grant counted on release.
- Outstanding limit: MAX_OUT = 2, 3 IC requests, no responses -> third waits in BLOCKED; a DC response pulse -> third issues within 1 cycle; dc_fill_done pulses 1 cycle after the response.
- Same-cycle handshake and response at outstanding = 1 -> outstanding stays 1. A spurious response at outstanding = 0 -> rsp_err = 1 and no done pulse.
- Clear with 3 queued entries and one in ISSUE -> queues empty, counters 0, held request still handshakes and ic_grants = 1 afterwards. rst_n low mid-ISSUE -> all outputs 0 immediately.
